// File: rtl/sipo_pkg.sv
// Shared definitions for the LSB-first serial-to-parallel deserializer.
package sipo_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Width of a counter able to hold 0..w
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Bit collector: shift register, bit counter and word-completion pulse.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned CW = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] word_c,
  output logic             done_c,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Flush wins over a valid bit; completion is only flagged on an accepted bit
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    done_c = 1'b0;
    word_c = {s_in, sreg_q[WIDTH-1:1]};
    if (clear) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else if (s_valid) begin
      sreg_d = word_c;
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d  = '0;
        done_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sipo_deser.sv
// Deserializer top: one-entry output register with valid/ready handshake
// and a sticky overrun flag for words dropped while the consumer stalls.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned CW = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  input  logic             p_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);

  logic [WIDTH-1:0] word_c;
  logic             done_c;

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] p_out_q, p_out_d;
  logic             overrun_q, overrun_d;

  sipo_shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_in   (s_in),
    .s_valid(s_valid),
    .clear  (clear),
    .word_c (word_c),
    .done_c (done_c),
    .cnt    (bit_cnt)
  );

  // Accept-and-refill on one edge keeps FULL without flagging overrun
  always_comb begin
    state_d   = state_q;
    p_out_d   = p_out_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_EMPTY: begin
        if (done_c) begin
          p_out_d = word_c;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (p_ready) begin
          if (done_c) p_out_d = word_c;
          else        state_d = ST_EMPTY;
        end else if (done_c) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (clear) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      p_out_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_out_q   <= p_out_d;
      overrun_q <= overrun_d;
    end
  end

  assign p_out   = p_out_q;
  assign p_valid = (state_q == ST_FULL);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (WIDTH=4) with a behavioural
// LSB-first serializer standing in for the upstream piso.
module tb_sipo_deser;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst_n;
  logic             s_in;
  logic             s_valid;
  logic             clear;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  int n_checks = 0;
  int n_errors = 0;

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_in   (s_in),
    .s_valid(s_valid),
    .clear  (clear),
    .p_out  (p_out),
    .p_valid(p_valid),
    .p_ready(p_ready),
    .bit_cnt(bit_cnt),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_in    = b;
    s_valid = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_in    = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Serialize a word LSB first, as piso would after a load
  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
  endtask

  logic [WIDTH-1:0] e2e_words [4];

  initial begin
    rst_n   = 1'b0;
    s_in    = 1'b0;
    s_valid = 1'b0;
    clear   = 1'b0;
    p_ready = 1'b1;
    e2e_words[0] = 4'b1010;
    e2e_words[1] = 4'b1111;
    e2e_words[2] = 4'b0000;
    e2e_words[3] = 4'b1100;

    step();
    step();
    chk("rst_p_out",   32'(p_out),   32'h0);
    chk("rst_p_valid", 32'(p_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);
    rst_n = 1'b1;

    // Basic word: bits 0,1,0,1 -> 1010, valid for exactly one cycle
    send_bit(1'b0);
    send_bit(1'b1);
    chk("basic_cnt2", 32'(bit_cnt), 32'd2);
    chk("basic_nv",   32'(p_valid), 32'h0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("basic_valid", 32'(p_valid), 32'h1);
    chk("basic_word",  32'(p_out),   32'hA);
    chk("basic_cnt0",  32'(bit_cnt), 32'h0);
    idle(1);
    chk("basic_one_cycle", 32'(p_valid), 32'h0);

    // Gapped input: counter frozen during gap
    send_bit(1'b1);
    send_bit(1'b1);
    idle(5);
    chk("gap_cnt_hold", 32'(bit_cnt), 32'd2);
    chk("gap_nv",       32'(p_valid), 32'h0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("gap_valid", 32'(p_valid), 32'h1);
    chk("gap_word",  32'(p_out),   32'h3);
    idle(1);

    // Stall and overrun
    p_ready = 1'b0;
    send_word(4'b1111);
    chk("stall_valid1", 32'(p_valid), 32'h1);
    chk("stall_word1",  32'(p_out),   32'hF);
    chk("stall_ovr0",   32'(overrun), 32'h0);
    send_word(4'b0000);
    chk("stall_word_kept", 32'(p_out),   32'hF);
    chk("stall_valid2",    32'(p_valid), 32'h1);
    chk("stall_ovr1",      32'(overrun), 32'h1);
    p_ready = 1'b1;
    idle(1);
    chk("stall_drain",     32'(p_valid), 32'h0);
    chk("stall_ovr_stick", 32'(overrun), 32'h1);

    // Clear flushes partial word (bit on clear edge discarded) and overrun
    send_bit(1'b1);
    clear   = 1'b1;
    s_in    = 1'b1;
    s_valid = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_cnt", 32'(bit_cnt), 32'h0);
    chk("clr_ovr", 32'(overrun), 32'h0);
    chk("clr_nv",  32'(p_valid), 32'h0);
    send_word(4'b0001);
    chk("clr_word", 32'(p_out), 32'h1);
    idle(1);

    // Simultaneous accept and complete
    p_ready = 1'b0;
    send_word(4'b1100);
    chk("sim_pend", 32'(p_out), 32'hC);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    p_ready = 1'b1;
    send_bit(1'b0);
    chk("sim_word",  32'(p_out),   32'h5);
    chk("sim_valid", 32'(p_valid), 32'h1);
    chk("sim_ovr",   32'(overrun), 32'h0);
    idle(1);
    chk("sim_drain", 32'(p_valid), 32'h0);

    // Reset mid-word with a pending word and overrun set
    p_ready = 1'b0;
    send_word(4'b1001);
    send_word(4'b0000);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("pre_rst_ovr", 32'(overrun), 32'h1);
    chk("pre_rst_cnt", 32'(bit_cnt), 32'd2);
    rst_n   = 1'b0;
    p_ready = 1'b1;
    idle(2);
    chk("mid_rst_p_out",   32'(p_out),   32'h0);
    chk("mid_rst_p_valid", 32'(p_valid), 32'h0);
    chk("mid_rst_overrun", 32'(overrun), 32'h0);
    chk("mid_rst_bit_cnt", 32'(bit_cnt), 32'h0);
    rst_n = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("post_rst_word",  32'(p_out),   32'h6);
    chk("post_rst_valid", 32'(p_valid), 32'h1);
    idle(1);

    // End-to-end: first two words back-to-back, then one-cycle load gaps
    for (int k = 0; k < 4; k++) begin
      send_word(e2e_words[k]);
      chk($sformatf("e2e_valid%0d", k), 32'(p_valid), 32'h1);
      chk($sformatf("e2e_word%0d", k),  32'(p_out),   32'(e2e_words[k]));
      if (k >= 1) idle(1);
    end
    chk("e2e_ovr", 32'(overrun), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in/parallel-out deserializer that consumes the LSB-first bit stream produced by the team's `piso` shift register and reassembles it into WIDTH-bit words. Bits are qualified by `s_valid`, counted into a shift register, and delivered through a one-entry output register with a valid/ready handshake. A sticky overrun flag records words dropped because the consumer stalled. The block sits directly downstream of `piso`, between the serial link and the parallel consumer.

## Interface
- `WIDTH`, default 4: word width in bits; legal values are 2 to 32.
- `clk` input 1: single clock; all activity occurs on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `s_in` input 1: serial data bit, LSB first.
- `s_valid` input 1: `s_in` is sampled only on edges where this is 1.
- `clear` input 1: synchronous flush of the partial word.
- `p_out` output WIDTH: assembled word; stable while `p_valid`=1.
- `p_valid` output 1: output register holds an unconsumed word.
- `p_ready` input 1: consumer accepts the word on an edge where `p_valid`=1 and `p_ready`=1.
- `bit_cnt` output clog2(WIDTH+1): number of bits collected in the current partial word (debug/observability).
- `overrun` output 1: sticky; set when a completed word is dropped.

## Operation
- Shift register `sreg[WIDTH-1:0]`. On a valid bit it updates as `{s_in, sreg[WIDTH-1:1]}`, so the first received bit ends in bit 0.
- Counter `cnt` runs 0..WIDTH-1:
  - It increments on each valid bit.
  - On a valid bit with `cnt`==WIDTH-1 the word completes and `cnt` returns to 0.
- Completed word value is `{s_in, sreg[WIDTH-1:1]}`.
- Output FSM has 2 states:
  - **EMPTY** (`p_valid`=0). On word completion, load `p_out` and go to FULL.
  - **FULL** (`p_valid`=1). Behaviour depends on `p_ready` and word completion:
    - `p_ready`=1 with no completion: go to EMPTY.
    - `p_ready`=1 with a completion on the same edge: load the new word and stay FULL. This is not an overrun.
    - `p_ready`=0 with a completion: drop the new word, keep the old `p_out`, set `overrun`.
- `clear`=1 takes priority over `s_valid`:
  - It zeroes `cnt` and `sreg`; the bit on that edge is discarded.
  - It does not touch `p_out`, `p_valid` or the handshake.
  - It also clears `overrun`.
- `s_valid`=0 freezes `sreg` and `cnt`; gaps between bits are unlimited.
- Reset (`rst_n`=0 at an edge) overrides everything:
  - `p_out`=0, `p_valid`=0, `overrun`=0, `bit_cnt`=0, `sreg`=0, state EMPTY.
  - Reset in the middle of a word discards the partial word.
- Arithmetic: `cnt` is unsigned with no wrap beyond WIDTH-1. No parity or framing is performed.

## Timing
- Each valid bit is sampled at the rising edge where `s_valid`=1.
- Latency: `p_valid` rises in the cycle after the edge that samples bit WIDTH-1, with `p_out` valid in that same cycle.
- Throughput: one word per WIDTH valid bits, back-to-back with no bubble, provided `p_ready` is held at 1.
- `p_valid` and `p_out` are registered outputs with no combinational path from any input.
- `overrun` goes high the cycle after the dropping edge and holds until `clear` or reset.
- `bit_cnt` reflects `cnt` after each edge.

## Structure
- Shared package `sipo_pkg` holds:
  - the `WIDTH` default constant;
  - the output-state typedef (`ST_EMPTY`, `ST_FULL`);
  - a `CNT_W` helper function (clog2(WIDTH+1)).
- One natural sub-module, `sipo_shift_core`, containing `sreg`, `cnt` and the completion pulse.
- The top level owns the output register, the FSM and `overrun`.

## Test plan
- **Basic word.** WIDTH=4, reset then `rst_n`=1; send bits 0,1,0,1 with `s_valid`=1 and `p_ready`=1 -> `p_out`=4'b1010 and `p_valid`=1 for exactly one cycle, one cycle after the 4th bit.
- **Gapped input.** Send 1,1 then `s_valid`=0 for 5 cycles, then 0,0 -> `p_out`=4'b0011 and `bit_cnt` holds at 2 during the gap.
- **Stall and overrun.** Hold `p_ready`=0; send 1111 then 0000 -> `p_out` stays 4'b1111, `p_valid`=1, `overrun`=1. Then raise `p_ready` -> `p_valid`=0 the next cycle and `overrun` remains 1.
- **Simultaneous accept and complete.** Word 4'b1100 is pending; `p_ready`=1 on the same edge that 4'b0101 completes -> `p_out`=4'b0101, `p_valid` stays 1, `overrun`=0.
- **Reset mid-word.** After 2 bits, hold `rst_n`=0 for 2 cycles -> all outputs 0. Then send 0,1,1,0 -> `p_out`=4'b0110.
- **End-to-end with `piso`.** Instantiate `piso` driving `s_in`, with `s_valid` high for 4 cycles after each load; load 1010, 1111, 0000, 1100 -> received words match in order.
